// File: rtl/lanectrl_pause_sequencer.sv
// Round-robin HS I/O clock pause sequencer: setup/grant/hold/recover framing per requester.
// Optional grant watchdog built when PAUSE_SEQ_TIMEOUT_EN is defined.
module lanectrl_pause_sequencer #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned RECOVER_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] DONE,
  output logic [NUM_REQ-1:0] GNT,
  output logic               HS_IO_CLK_PAUSE,
  output logic               BUSY,
  output logic               TIMEOUT_ERR
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned IdxW1 = IdxW + 1;

  localparam logic [CNT_W-1:0] SetupLd   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLd    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RecoverLd = CNT_W'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StGrant, StHold, StRecover} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IdxW-1:0]    sel_q;
  logic [IdxW-1:0]    rr_ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               pause_q;

  logic               pick_valid;
  logic [IdxW-1:0]    pick_idx;
  logic [IdxW:0]      cand;
  logic [IdxW-1:0]    rr_next;

  // First requester at or after rr_ptr, wrapping around NUM_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + IdxW1'(i);
      if (cand >= IdxW1'(NUM_REQ)) cand = cand - IdxW1'(NUM_REQ);
      if (!pick_valid && REQ[cand[IdxW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign rr_next = (sel_q == IdxW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

`ifdef PAUSE_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLd = CNT_W'(TIMEOUT_CYCLES - 1);
  logic err_q;
  assign TIMEOUT_ERR = err_q;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      pause_q  <= 1'b0;
`ifdef PAUSE_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
`ifdef PAUSE_SEQ_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q <= StSetup;
            sel_q   <= pick_idx;
            cnt_q   <= SetupLd;
            pause_q <= 1'b1;
          end
        end
        StSetup: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (REQ[sel_q]) begin
            state_q <= StGrant;
            gnt_q   <= NUM_REQ'(1) << sel_q;
`ifdef PAUSE_SEQ_TIMEOUT_EN
            cnt_q   <= TimeoutLd;
`endif
          end else begin
            // Requester withdrew during setup: close the window without a grant.
            state_q  <= StHold;
            cnt_q    <= HoldLd;
            rr_ptr_q <= rr_next;
          end
        end
        StGrant: begin
          if (DONE[sel_q]) begin
            state_q  <= StHold;
            gnt_q    <= '0;
            cnt_q    <= HoldLd;
            rr_ptr_q <= rr_next;
          end
`ifdef PAUSE_SEQ_TIMEOUT_EN
          else if (cnt_q == '0) begin
            state_q  <= StHold;
            gnt_q    <= '0;
            cnt_q    <= HoldLd;
            rr_ptr_q <= rr_next;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
`endif
        end
        StHold: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= StRecover;
            pause_q <= 1'b0;
            cnt_q   <= RecoverLd;
          end
        end
        StRecover: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          pause_q <= 1'b0;
        end
      endcase
    end
  end

  assign GNT             = gnt_q;
  assign HS_IO_CLK_PAUSE = pause_q;
  assign BUSY            = (state_q != StIdle);

endmodule

// File: tb/tb_lanectrl_pause_sequencer.sv
// Self-checking bench for lanectrl_pause_sequencer; window timelines derived from cycle counts.
module tb_lanectrl_pause_sequencer;

  localparam int N     = 4;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int REC   = 4;
  localparam int TMO   = 15;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [N-1:0] REQ;
  logic [N-1:0] DONE;
  logic [N-1:0] GNT;
  logic         HS_IO_CLK_PAUSE;
  logic         BUSY;
  logic         TIMEOUT_ERR;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;

  lanectrl_pause_sequencer #(
    .NUM_REQ       (N),
    .CNT_W         (4),
    .SETUP_CYCLES  (SETUP),
    .HOLD_CYCLES   (HOLD),
    .RECOVER_CYCLES(REC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .REQ            (REQ),
    .DONE           (DONE),
    .GNT            (GNT),
    .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE),
    .BUSY           (BUSY),
    .TIMEOUT_ERR    (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // One pause window from an idle start. Expected outputs come from the window length rules:
  // pause for setup+grant+hold cycles, grant for glen cycles, busy until recovery ends.
  task automatic run_window(input string name, input logic [N-1:0] vec, input bit abort,
                            input int glen, input bit tmo);
    int           sel;
    int           g;
    int           tot;
    logic [N-1:0] selb;
    logic [N+2:0] exp_o;
    logic [N+2:0] obs;
    sel = -1;
    for (int i = 0; i < N; i++) if (sel < 0 && vec[(rr_m + i) % N]) sel = (rr_m + i) % N;
    selb      = '0;
    selb[sel] = 1'b1;
    g   = abort ? 0 : (tmo ? TMO : glen);
    tot = SETUP + g + HOLD + REC + 1;
    REQ  = vec;
    DONE = '0;
    for (int t = 1; t <= tot; t++) begin
      @(posedge CLK);
      #1;
      exp_o = {(t <= SETUP + g + HOLD), (t < tot), (tmo && t == SETUP + g + 1),
               ((t > SETUP && t <= SETUP + g) ? selb : {N{1'b0}})};
      obs = {HS_IO_CLK_PAUSE, BUSY, TIMEOUT_ERR, GNT};
      n_vec++;
      if (obs !== exp_o) begin
        n_err++;
        $display("FAIL %s cycle %0d {pause,busy,err,gnt}: got %b, want %b", name, t, obs, exp_o);
      end
      DONE = '0;
      if (abort && t == 1) REQ = vec & ~selb;
      if (!abort && t > SETUP && t <= SETUP + g) begin
        // Foreign DONE bits must be ignored while granted.
        DONE = N'($urandom) & ~selb;
        if (t == SETUP + g) begin
          if (!tmo) DONE = DONE | selb;
          REQ = vec & ~selb;
        end
      end
    end
    DONE = '0;
    rr_m = (sel + 1) % N;
  endtask

  task automatic idle_gap(input int cycles);
    REQ  = '0;
    DONE = '0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge CLK);
      #1;
      n_vec++;
      if ({HS_IO_CLK_PAUSE, BUSY, TIMEOUT_ERR, GNT} !== '0) begin
        n_err++;
        $display("FAIL idle_gap: got %b, want 0", {HS_IO_CLK_PAUSE, BUSY, TIMEOUT_ERR, GNT});
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    REQ   = '0;
    DONE  = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_vec++;
    if ({HS_IO_CLK_PAUSE, BUSY, TIMEOUT_ERR, GNT} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %b, want 0", {HS_IO_CLK_PAUSE, BUSY, TIMEOUT_ERR, GNT});
    end
    #3 RESET = 1'b0;
    rr_m = 0;
    idle_gap(2);
  endtask

  task automatic test_single_window();
    run_window("single", 4'b0010, 1'b0, 3, 1'b0);
    idle_gap(1);
  endtask

  task automatic test_round_robin();
    int exp_sel;
    for (int w = 0; w < 5; w++) begin
      exp_sel = rr_m;
      run_window("round_robin", 4'b1111, 1'b0, 1, 1'b0);
      n_vec++;
      if (rr_m !== (exp_sel + 1) % N) begin
        n_err++;
        $display("FAIL round_robin_ptr: got %0d, want %0d", rr_m, (exp_sel + 1) % N);
      end
    end
  endtask

  task automatic test_abort();
    run_window("abort", 4'b0100, 1'b1, 0, 1'b0);
    run_window("after_abort", 4'b1011, 1'b0, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] vec;
    for (int w = 0; w < 20; w++) begin
      vec = N'($urandom_range(1, (1 << N) - 1));
      run_window("random", vec, ($urandom_range(0, 3) == 0), $urandom_range(1, 6), 1'b0);
      idle_gap($urandom_range(0, 3));
    end
  endtask

  task automatic test_async_reset();
    run_window("pre_reset", 4'b0010, 1'b0, 1, 1'b0);
    REQ = 4'b0100;
    repeat (SETUP + 2) @(posedge CLK);
    #1;
    n_vec++;
    if (GNT !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_grant_setup: got %b, want 0100", GNT);
    end
    #2 RESET = 1'b1;
    REQ = '0;
    #1;
    n_vec++;
    if ({HS_IO_CLK_PAUSE, BUSY, GNT} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %b, want 0", {HS_IO_CLK_PAUSE, BUSY, GNT});
    end
    #1 RESET = 1'b0;
    rr_m = 0;
    idle_gap(2);
    run_window("post_reset", 4'b1111, 1'b0, 2, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef PAUSE_SEQ_TIMEOUT_EN
    run_window("timeout", 4'b0001, 1'b0, 0, 1'b1);
`else
    run_window("no_timeout", 4'b0001, 1'b0, 110, 1'b0);
`endif
    idle_gap(2);
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_round_robin();
    test_abort();
    test_random();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
